// File: rtl/agc_rms_accum.sv
// Windowed sum-of-squares and peak accumulator for the AGC RMS path.
// Two-stage pipeline (square, accumulate) with a valid/ack result register and sticky overrun flag.
module agc_rms_accum #(
  parameter int unsigned NBITS_LEN = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             in_i,
  input  logic                   sync_i,
  input  logic [NBITS_LEN-1:0]   len_i,
  input  logic                   cont_i,
  input  logic                   ack_i,
  output logic [NBITS_LEN+7:0]   sq_o,
  output logic [3:0]             peak_o,
  output logic                   valid_o,
  output logic                   overrun_o,
  output logic                   busy_o
);

  localparam int unsigned AccW = NBITS_LEN + 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Window control
  state_e               state_q, state_d;
  logic [NBITS_LEN-1:0] cnt_q, cnt_d;
  logic                 first_q, first_d;

  // Stage 1: squared sample and window-position flags
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;
  logic [7:0]           s1_sq_q, s1_sq_d;
  logic [3:0]           s1_pk_q, s1_pk_d;

  // Stage 2: running accumulators and the presented result
  logic [AccW-1:0]      acc_q, acc_d;
  logic [3:0]           pk_acc_q, pk_acc_d;
  logic [AccW-1:0]      sq_q, sq_d;
  logic [3:0]           peak_q, peak_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic                 take;
  logic                 last;
  logic                 result_load;

  // A sample is taken every RUN cycle except a sync cycle, which restarts the window.
  assign take = (state_q == ST_RUN) && !sync_i;
  assign last = take && (cnt_q == '0);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (sync_i) begin
      state_d = ST_RUN;
      cnt_d   = len_i;
      first_d = 1'b1;
    end else if (take) begin
      first_d = last && cont_i;
      if (last) begin
        if (cont_i) begin
          cnt_d = len_i;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        cnt_d = cnt_q - NBITS_LEN'(1);
      end
    end
  end

  always_comb begin
    s1_valid_d = take;
    s1_first_d = take && first_q;
    s1_last_d  = last;
    s1_sq_d    = {4'b0000, in_i} * {4'b0000, in_i};
    s1_pk_d    = in_i;
  end

  always_comb begin
    acc_d    = acc_q;
    pk_acc_d = pk_acc_q;
    if (s1_valid_q) begin
      acc_d    = s1_first_q ? {{NBITS_LEN{1'b0}}, s1_sq_q}
                            : acc_q + {{NBITS_LEN{1'b0}}, s1_sq_q};
      pk_acc_d = (s1_first_q || (s1_pk_q > pk_acc_q)) ? s1_pk_q : pk_acc_q;
    end

    result_load = s1_valid_q && s1_last_q;
    sq_d        = result_load ? acc_d    : sq_q;
    peak_d      = result_load ? pk_acc_d : peak_q;
    // A result landing in the same cycle as an ack counts as delivered, not overrun.
    valid_d     = result_load || (valid_q && !ack_i);
    overrun_d   = overrun_q || (result_load && valid_q && !ack_i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  // NOTE: the accumulators are reset too; together with the cleared stage-1 flags no stale window can report.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sq_q    <= '0;
      s1_pk_q    <= '0;
      acc_q      <= '0;
      pk_acc_q   <= '0;
      sq_q       <= '0;
      peak_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_sq_q    <= s1_sq_d;
      s1_pk_q    <= s1_pk_d;
      acc_q      <= acc_d;
      pk_acc_q   <= pk_acc_d;
      sq_q       <= sq_d;
      peak_q     <= peak_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sq_o      = sq_q;
  assign peak_o    = peak_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q == ST_RUN);

endmodule

// File: tb/tb_agc_rms_accum.sv
// Directed bench for agc_rms_accum; a narrow second instance exercises the full-length window.
module tb_agc_rms_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  in_v = '0;
  logic        sync = 1'b0;
  logic [23:0] len = '0;
  logic        cont = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] sq;
  logic [3:0]  peak;
  logic        valid, overrun, busy;

  logic [11:0] len_s = '0;
  logic [19:0] sq_s;
  logic [3:0]  peak_s;
  logic        valid_s, overrun_s, busy_s;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  agc_rms_accum #(.NBITS_LEN(24)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in_v), .sync_i(sync), .len_i(len),
    .cont_i(cont), .ack_i(ack), .sq_o(sq), .peak_o(peak), .valid_o(valid),
    .overrun_o(overrun), .busy_o(busy)
  );

  agc_rms_accum #(.NBITS_LEN(12)) dut_s (
    .clk_i(clk), .rst_i(rst), .in_i(in_v), .sync_i(sync), .len_i(len_s),
    .cont_i(cont), .ack_i(ack), .sq_o(sq_s), .peak_o(peak_s), .valid_o(valid_s),
    .overrun_o(overrun_s), .busy_o(busy_s)
  );

  // Advance into the next cycle; outputs are stable and inputs may be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 1'b0; ack = 1'b0; in_v = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (sq !== 32'd0) begin failed++; $display("FAIL reset_sq: got %0d expected 0", sq); end
    tests++; if (peak !== 4'd0) begin failed++; $display("FAIL reset_peak: got %0d expected 0", peak); end
    tests++; if ({valid, overrun, busy} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b expected 000", {valid, overrun, busy}); end
    tests++; if ({valid_s, overrun_s, busy_s} !== 3'b000) begin failed++; $display("FAIL reset_flags_s: got %b expected 000", {valid_s, overrun_s, busy_s}); end
    rst = 1'b0;
  endtask

  task automatic test_single_shot();
    do_reset();
    len = 24'd3; cont = 1'b0; sync = 1'b1; in_v = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      sync = 1'b0;
      in_v = (k <= 4) ? 4'(k) : 4'd0;
      ack  = (k == 7);
      if (k == 1) begin
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL ss_busy_c1: got %b expected 1", busy); end
      end
      if (k == 5) begin
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL ss_busy_c5: got %b expected 0", busy); end
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL ss_valid_c5: got %b expected 0", valid); end
      end
      if (k == 6) begin
        tests++; if (valid !== 1'b1) begin failed++; $display("FAIL ss_valid_c6: got %b expected 1", valid); end
        tests++; if (sq !== 32'd30) begin failed++; $display("FAIL ss_sq: got %0d expected 30", sq); end
        tests++; if (peak !== 4'd4) begin failed++; $display("FAIL ss_peak: got %0d expected 4", peak); end
      end
      if (k == 7) begin
        tests++; if (valid !== 1'b1) begin failed++; $display("FAIL ss_valid_c7: got %b expected 1", valid); end
      end
      if (k == 8) begin
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL ss_ack_clear: got %b expected 0", valid); end
        tests++; if (sq !== 32'd30) begin failed++; $display("FAIL ss_sq_hold: got %0d expected 30", sq); end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    len = 24'd1; cont = 1'b0; sync = 1'b1; in_v = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      step();
      sync = (k == 3);
      ack  = (k == 4);
      case (k)
        1: in_v = 4'd7;
        2: in_v = 4'd1;
        5: in_v = 4'd2;
        default: in_v = 4'd0;
      endcase
      if (k == 3) begin
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL b2b_idle: got %b expected 0", busy); end
      end
      if (k == 4) begin
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        tests++; if ({valid, sq, peak} !== {1'b1, 32'd50, 4'd7}) begin failed++; $display("FAIL b2b_res1: got v=%b sq=%0d pk=%0d expected v=1 sq=50 pk=7", valid, sq, peak); end
      end
      if (k == 5) begin
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL b2b_ack: got %b expected 0", valid); end
      end
      if (k == 7) begin
        tests++; if ({valid, overrun, sq, peak} !== {2'b10, 32'd4, 4'd2}) begin failed++; $display("FAIL b2b_res2: got v=%b ovr=%b sq=%0d pk=%0d expected v=1 ovr=0 sq=4 pk=2", valid, overrun, sq, peak); end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_len_zero_cont();
    do_reset();
    len = 24'd0; cont = 1'b1; sync = 1'b1; in_v = 4'd15;
    for (int k = 1; k <= 6; k++) begin
      step();
      sync = 1'b0;
      if (k == 2) begin
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL n1_valid_c2: got %b expected 0", valid); end
      end
      if (k == 3) begin
        tests++; if ({valid, overrun, sq, peak} !== {2'b10, 32'd225, 4'd15}) begin failed++; $display("FAIL n1_c3: got v=%b ovr=%b sq=%0d pk=%0d expected v=1 ovr=0 sq=225 pk=15", valid, overrun, sq, peak); end
      end
      if (k == 4) begin
        tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL n1_overrun: got %b expected 1", overrun); end
      end
      if (k == 6) begin
        tests++; if ({valid, overrun, busy, sq} !== {3'b111, 32'd225}) begin failed++; $display("FAIL n1_c6: got v=%b ovr=%b busy=%b sq=%0d expected 1 1 1 225", valid, overrun, busy, sq); end
      end
    end
  endtask

  task automatic test_max_window();
    do_reset();
    len = 24'hFFFFFF; len_s = 12'hFFF; cont = 1'b0; sync = 1'b1; in_v = 4'd15;
    for (int k = 1; k <= 4098; k++) begin
      step();
      sync = 1'b0;
      if (k == 4097) begin
        tests++; if ({valid_s, busy_s} !== 2'b00) begin failed++; $display("FAIL max_c4097: got v=%b busy=%b expected 0 0", valid_s, busy_s); end
      end
      if (k == 4098) begin
        tests++; if (valid_s !== 1'b1) begin failed++; $display("FAIL max_valid: got %b expected 1", valid_s); end
        tests++; if (sq_s !== 20'hE1000) begin failed++; $display("FAIL max_sq: got %h expected e1000", sq_s); end
        tests++; if (peak_s !== 4'd15) begin failed++; $display("FAIL max_peak: got %0d expected 15", peak_s); end
      end
    end
  endtask

  task automatic test_sync_restart();
    do_reset();
    len = 24'd7; cont = 1'b1; sync = 1'b1; in_v = 4'd2;
    for (int k = 1; k <= 15; k++) begin
      step();
      sync = (k == 5);
      if (k < 15) begin
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL rs_novalid_c%0d: got %b expected 0", k, valid); end
      end else begin
        tests++; if ({valid, sq, peak} !== {1'b1, 32'd32, 4'd2}) begin failed++; $display("FAIL rs_result: got v=%b sq=%0d pk=%0d expected v=1 sq=32 pk=2", valid, sq, peak); end
      end
    end
  endtask

  // Continues from test_sync_restart: its result (32) is still held when the new window starts.
  task automatic test_reset_mid_window();
    len = 24'd7; cont = 1'b0; sync = 1'b1; in_v = 4'd5;
    for (int k = 1; k <= 24; k++) begin
      step();
      sync = 1'b0;
      rst  = (k == 3);
      if (k == 2) begin
        tests++; if ({valid, busy, sq} !== {2'b11, 32'd32}) begin failed++; $display("FAIL rm_before: got v=%b busy=%b sq=%0d expected 1 1 32", valid, busy, sq); end
      end
      if (k == 4) begin
        tests++; if ({sq, peak, valid, overrun, busy} !== 39'd0) begin failed++; $display("FAIL rm_zero: got sq=%0d pk=%0d v=%b ovr=%b busy=%b expected all 0", sq, peak, valid, overrun, busy); end
      end
      if (k > 4) begin
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL rm_novalid_c%0d: got %b expected 0", k, valid); end
      end
    end
  endtask

  task automatic test_sync_edges();
    do_reset();
    len = 24'd3; cont = 1'b1; sync = 1'b1; in_v = 4'd3;
    for (int k = 1; k <= 12; k++) begin
      step();
      sync = (k == 5) || (k == 9);
      ack  = (k == 6);
      if (k == 6) begin
        tests++; if ({valid, sq, peak} !== {1'b1, 32'd36, 4'd3}) begin failed++; $display("FAIL se_complete: got v=%b sq=%0d pk=%0d expected v=1 sq=36 pk=3", valid, sq, peak); end
      end
      if (k == 7 || k == 11 || k == 12) begin
        tests++; if (valid !== 1'b0) begin failed++; $display("FAIL se_novalid_c%0d: got %b expected 0", k, valid); end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_len_change();
    do_reset();
    len = 24'd3; cont = 1'b1; sync = 1'b1; in_v = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      step();
      sync = 1'b0;
      in_v = 4'(k);
      if (k == 2) len = 24'd1;
      ack = (k == 7);
      if (k == 3) begin
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL lc_busy: got %b expected 1", busy); end
      end
      if (k == 6) begin
        tests++; if ({valid, sq, peak} !== {1'b1, 32'd30, 4'd4}) begin failed++; $display("FAIL lc_win1: got v=%b sq=%0d pk=%0d expected v=1 sq=30 pk=4", valid, sq, peak); end
      end
      if (k == 8) begin
        tests++; if ({valid, overrun, sq, peak} !== {2'b10, 32'd61, 4'd6}) begin failed++; $display("FAIL lc_win2: got v=%b ovr=%b sq=%0d pk=%0d expected v=1 ovr=0 sq=61 pk=6", valid, overrun, sq, peak); end
      end
      if (k == 10) begin
        tests++; if ({valid, overrun, sq, peak} !== {2'b11, 32'd113, 4'd8}) begin failed++; $display("FAIL lc_win3: got v=%b ovr=%b sq=%0d pk=%0d expected v=1 ovr=1 sq=113 pk=8", valid, overrun, sq, peak); end
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_back_to_back();
    test_len_zero_cont();
    test_max_window();
    test_sync_restart();
    test_reset_mid_window();
    test_sync_edges();
    test_len_change();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
